// File: rtl/rc4_search_pkg.sv
// Shared types and constants for the RC4 key search datapath.
// Plaintext character bounds are shared by the key search and the ROM-compare stage.
package rc4_search_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t CHAR_LO    = 8'h61;
   localparam byte_t CHAR_HI    = 8'h7A;
   localparam byte_t CHAR_SPACE = 8'h20;

   typedef enum logic [2:0] {
      KS_IDLE,
      KS_ISSUE,
      KS_WAIT_CORE,
      KS_CHECK,
      KS_NEXT,
      KS_FOUND,
      KS_EXHAUSTED
   } ks_state_t;

endpackage

// File: rtl/plaintext_byte_check.sv
// Flags a decrypted byte as plausible plaintext: lowercase a-z or space.
module plaintext_byte_check
   import rc4_search_pkg::*;
(
   input  byte_t data_byte,
   output logic  valid
);

   always_comb begin
      valid = ((data_byte >= CHAR_LO) && (data_byte <= CHAR_HI)) || (data_byte == CHAR_SPACE);
   end

endmodule

// File: rtl/key_search_controller.sv
// RC4 key search controller: issues candidate keys to decryption_core and scans its plaintext.
// KEY_SEARCH_STRIDE_EN adds CORE_INDEX/NUM_CORES so several cores can partition the key space.
module key_search_controller
   import rc4_search_pkg::*;
#(
   parameter int unsigned          MSG_DEP   = 32,
   parameter int unsigned          KEY_WIDTH = 24,
   parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
   parameter logic [KEY_WIDTH-1:0] KEY_END   = 24'h3FFFFF
`ifdef KEY_SEARCH_STRIDE_EN
   ,
   parameter int unsigned          CORE_INDEX = 0,
   parameter int unsigned          NUM_CORES  = 1
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 core_done,
   input  logic [8*MSG_DEP-1:0] decrypted_data,
   output logic [KEY_WIDTH-1:0] secret_key,
   output logic                 new_key_available,
   output logic                 busy,
   output logic                 key_found,
   output logic                 search_exhausted,
   output logic [KEY_WIDTH:0]   keys_tried
);

   localparam int unsigned EXT_W = KEY_WIDTH + 1;
   localparam int unsigned IDX_W = (MSG_DEP > 1) ? $clog2(MSG_DEP) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_DEP - 1);

`ifdef KEY_SEARCH_STRIDE_EN
   localparam logic [EXT_W-1:0] FIRST_KEY = {1'b0, KEY_START} + EXT_W'(CORE_INDEX);
   localparam logic [EXT_W-1:0] KEY_STEP  = EXT_W'(NUM_CORES);
`else
   localparam logic [EXT_W-1:0] FIRST_KEY = {1'b0, KEY_START};
   localparam logic [EXT_W-1:0] KEY_STEP  = EXT_W'(1);
`endif

   ks_state_t            state_q, state_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic [EXT_W-1:0]     tried_q, tried_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 done_q;
   byte_t                data_q [MSG_DEP];
   byte_t                data_d [MSG_DEP];
   logic                 nka_q, nka_d;
   logic                 busy_q, busy_d;
   logic                 found_q, found_d;
   logic                 exh_q, exh_d;

   logic                 core_rise;
   logic [EXT_W-1:0]     next_key;
   byte_t                cur_byte;
   logic                 byte_valid;

   assign cur_byte = data_q[idx_q];

   plaintext_byte_check u_byte_check (
      .data_byte (cur_byte),
      .valid     (byte_valid)
   );

   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      tried_d   = tried_q;
      idx_d     = idx_q;
      data_d    = data_q;
      found_d   = found_q;
      exh_d     = exh_q;
      core_rise = core_done & ~done_q;
      // Extra bit keeps the step from wrapping past the top of the key space.
      next_key  = {1'b0, key_q} + KEY_STEP;

      if (abort) begin
         state_d = KS_IDLE;
         found_d = 1'b0;
         exh_d   = 1'b0;
      end else begin
         case (state_q)
            KS_IDLE, KS_FOUND, KS_EXHAUSTED: begin
               if (start) begin
                  key_d   = FIRST_KEY[KEY_WIDTH-1:0];
                  tried_d = '0;
                  found_d = 1'b0;
                  exh_d   = 1'b0;
                  state_d = KS_ISSUE;
               end
            end
            KS_ISSUE: begin
               state_d = KS_WAIT_CORE;
            end
            KS_WAIT_CORE: begin
               if (core_rise) begin
                  for (int unsigned i = 0; i < MSG_DEP; i++) begin
                     data_d[i] = decrypted_data[8*i +: 8];
                  end
                  idx_d   = '0;
                  state_d = KS_CHECK;
               end
            end
            KS_CHECK: begin
               if (!byte_valid) begin
                  state_d = KS_NEXT;
               end else if (idx_q == LAST_IDX) begin
                  tried_d = tried_q + EXT_W'(1);
                  found_d = 1'b1;
                  state_d = KS_FOUND;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
            KS_NEXT: begin
               tried_d = tried_q + EXT_W'(1);
               if (next_key > {1'b0, KEY_END}) begin
                  exh_d   = 1'b1;
                  state_d = KS_EXHAUSTED;
               end else begin
                  key_d   = next_key[KEY_WIDTH-1:0];
                  state_d = KS_ISSUE;
               end
            end
            default: begin
               state_d = KS_IDLE;
            end
         endcase
      end

      // Pulse and busy are registered from the next state so they align with it.
      nka_d  = (state_d == KS_ISSUE);
      busy_d = (state_d == KS_ISSUE) || (state_d == KS_WAIT_CORE) ||
               (state_d == KS_CHECK) || (state_d == KS_NEXT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= KS_IDLE;
         key_q   <= KEY_START;
         tried_q <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         data_q  <= '{default: '0};
         nka_q   <= 1'b0;
         busy_q  <= 1'b0;
         found_q <= 1'b0;
         exh_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         tried_q <= tried_d;
         idx_q   <= idx_d;
         done_q  <= core_done;
         data_q  <= data_d;
         nka_q   <= nka_d;
         busy_q  <= busy_d;
         found_q <= found_d;
         exh_q   <= exh_d;
      end
   end

   assign secret_key        = key_q;
   assign new_key_available = nka_q;
   assign busy              = busy_q;
   assign key_found         = found_q;
   assign search_exhausted  = exh_q;
   assign keys_tried        = tried_q;

endmodule

// File: tb/tb_key_search_controller.sv
// Directed-sequence bench for key_search_controller with a randomized decryption_core model.
`timescale 1ns/1ps
module tb_key_search_controller;

   localparam int unsigned MSG_DEP = 32;
   localparam int unsigned KW      = 24;
`ifdef KEY_SEARCH_STRIDE_EN
   localparam int unsigned FIRST = 1;
   localparam int unsigned STEP  = 4;
`else
   localparam int unsigned FIRST = 0;
   localparam int unsigned STEP  = 1;
`endif
   localparam int unsigned END_A = 24'h3FFFFF;
   localparam int unsigned END_B = 3;

   localparam int M_NEVER     = 0;
   localparam int M_TARGET    = 1;
   localparam int M_BAD_FIRST = 2;
   localparam int M_BAD_LAST  = 3;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 start_a = 1'b0, start_b = 1'b0;
   logic                 abort_a = 1'b0, abort_b = 1'b0;
   logic                 core_done = 1'b0;
   logic [8*MSG_DEP-1:0] decrypted_data = '0;

   logic [KW-1:0] key_a, key_b;
   logic          nka_a, nka_b, busy_a, busy_b, found_a, found_b, exh_a, exh_b;
   logic [KW:0]   tried_a, tried_b;

   int           checks = 0;
   int           errors = 0;
   int unsigned  cycle = 0;
   int           mode = M_NEVER;
   int unsigned  target = 0;
   bit           hold_done = 1'b0;
   int unsigned  want = 0;

   int unsigned  core_key = 0;
   int unsigned  core_cnt = 0;
   int unsigned  pulses_a = 0;
   int unsigned  pulses_b = 0;
   int unsigned  issued_a [0:255];

   key_search_controller #(
      .MSG_DEP   (MSG_DEP),
      .KEY_WIDTH (KW),
      .KEY_START (24'h000000),
      .KEY_END   (24'h3FFFFF)
`ifdef KEY_SEARCH_STRIDE_EN
      ,
      .CORE_INDEX(1),
      .NUM_CORES (4)
`endif
   ) dut_a (
      .clk               (clk),
      .reset             (reset),
      .start             (start_a),
      .abort             (abort_a),
      .core_done         (core_done),
      .decrypted_data    (decrypted_data),
      .secret_key        (key_a),
      .new_key_available (nka_a),
      .busy              (busy_a),
      .key_found         (found_a),
      .search_exhausted  (exh_a),
      .keys_tried        (tried_a)
   );

   key_search_controller #(
      .MSG_DEP   (MSG_DEP),
      .KEY_WIDTH (KW),
      .KEY_START (24'h000000),
      .KEY_END   (24'h000003)
`ifdef KEY_SEARCH_STRIDE_EN
      ,
      .CORE_INDEX(1),
      .NUM_CORES (4)
`endif
   ) dut_b (
      .clk               (clk),
      .reset             (reset),
      .start             (start_b),
      .abort             (abort_b),
      .core_done         (core_done),
      .decrypted_data    (decrypted_data),
      .secret_key        (key_b),
      .new_key_available (nka_b),
      .busy              (busy_b),
      .key_found         (found_b),
      .search_exhausted  (exh_b),
      .keys_tried        (tried_b)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   function automatic logic [7:0] bad_byte();
      case ($urandom_range(7, 0))
         0: return 8'h60;
         1: return 8'h7B;
         2: return 8'h1F;
         3: return 8'h21;
         4: return 8'h41;
         5: return 8'h00;
         6: return 8'hFF;
         default: return 8'h5A;
      endcase
   endfunction

   // Plaintext the core would produce for a key under the current scenario.
   function automatic logic [8*MSG_DEP-1:0] gen_msg(int unsigned key);
      logic [8*MSG_DEP-1:0] m;
      int unsigned          r;
      int unsigned          pos;
      logic [7:0]           bv;
      for (int i = 0; i < MSG_DEP; i++) begin
         r = $urandom_range(26, 0);
         m[8*i +: 8] = (r == 26) ? 8'h20 : (8'h61 + r[7:0]);
      end
      if (mode == M_TARGET && key == target) begin
         if (target == FIRST) m = {MSG_DEP{8'h20}};
         return m;
      end
      case (mode)
         M_BAD_FIRST: begin pos = 0; bv = 8'h41; end
         M_BAD_LAST:  begin pos = MSG_DEP - 1; bv = 8'h7B; end
         default:     begin pos = $urandom_range(MSG_DEP - 1, 0); bv = bad_byte(); end
      endcase
      m[8*pos +: 8] = bv;
      return m;
   endfunction

   // Behavioural decryption_core: restarts on each key pulse, answers after a random latency.
   always @(negedge clk) begin
      if (nka_a || nka_b) begin
         core_key <= nka_a ? int'(key_a) : int'(key_b);
         core_cnt <= $urandom_range(5, 3);
         if (!hold_done) core_done <= 1'b0;
         if (nka_a) begin
            issued_a[pulses_a[7:0]] <= int'(key_a);
            pulses_a <= pulses_a + 1;
         end
         if (nka_b) pulses_b <= pulses_b + 1;
      end else if (core_cnt != 0) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1) begin
            decrypted_data <= gen_msg(core_key);
            core_done      <= 1'b1;
         end else begin
            core_done <= 1'b0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit cond(int sel);
      case (sel)
         0: return found_a | exh_a;
         1: return found_b | exh_b;
         2: return core_done;
         3: return nka_b | exh_b;
         4: return pulses_a >= want;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input int max_cycles);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         if (cond(sel)) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check(tag, {31'b0, ok}, 32'd1);
   endtask

   // Reference search: walk the key list and stop at the first valid message.
   task automatic model(input int unsigned end_key, output bit found, output int unsigned last,
                        output int unsigned n);
      found = 1'b0;
      n     = 0;
      last  = FIRST;
      for (longint unsigned k = FIRST; k <= end_key; k += STEP) begin
         n++;
         last = int'(k);
         if (mode == M_TARGET && k == target) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit          exp_found;
      int unsigned exp_last, exp_n, base, c0, gap;

      repeat (3) tick();
      check("rst_key", key_a, 0);
      check("rst_nka", nka_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_found", found_a, 0);
      check("rst_exh", exh_a, 0);
      check("rst_tried", tried_a, 0);
      reset = 1'b1;
      tick();

      // Single valid key at the first position: all-space message.
      mode = M_TARGET;
      target = FIRST;
      model(END_A, exp_found, exp_last, exp_n);
      base = pulses_a;
      start_a = 1'b1; tick(); start_a = 1'b0;
      wait_for("t1_done_to", 2, 50);
      c0 = cycle;
      wait_for("t1_found_to", 0, 200);
      gap = cycle - c0;
      check("t1_found", found_a, exp_found);
      check("t1_exh", exh_a, 0);
      check("t1_key", key_a, exp_last);
      check("t1_tried", tried_a, exp_n);
      check("t1_pulses", pulses_a - base, exp_n);
      check("t1_check_cycles", gap - 1, MSG_DEP);
      check("t1_busy", busy_a, 0);

      // Valid key at the sixth position; core_done left high across each restart.
      hold_done = 1'b1;
      target = FIRST + 5 * STEP;
      model(END_A, exp_found, exp_last, exp_n);
      base = pulses_a;
      start_a = 1'b1; tick(); start_a = 1'b0;
      want = base + 2;
      wait_for("t2_pulse2_to", 4, 300);
      start_a = 1'b1; tick(); start_a = 1'b0;
      wait_for("t2_found_to", 0, 2000);
      hold_done = 1'b0;
      check("t2_found", found_a, exp_found);
      check("t2_key", key_a, exp_last);
      check("t2_tried", tried_a, exp_n);
      check("t2_pulses", pulses_a - base, exp_n);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t2_issued%0d", i), issued_a[(base + i) % 256], FIRST + i * STEP);
      end

      abort_a = 1'b1; tick(); abort_a = 1'b0;
      check("abort_found", found_a, 0);
      check("abort_key_held", key_a, exp_last);

      // Small key space, never valid.
      mode = M_NEVER;
      model(END_B, exp_found, exp_last, exp_n);
      base = pulses_b;
      start_b = 1'b1; tick(); start_b = 1'b0;
      wait_for("t3_end_to", 1, 2000);
      check("t3_exh", exh_b, 1);
      check("t3_found", found_b, exp_found);
      check("t3_key", key_b, exp_last);
      check("t3_tried", tried_b, exp_n);
      check("t3_pulses", pulses_b - base, exp_n);
      repeat (20) tick();
      check("t3_no_extra_pulse", pulses_b - base, exp_n);
      check("t3_exh_held", exh_b, 1);

      // Early exit on first byte.
      mode = M_BAD_FIRST;
      start_b = 1'b1; tick(); start_b = 1'b0;
      wait_for("t4_done_to", 2, 50);
      c0 = cycle;
      tick();
      wait_for("t4_next_to", 3, 100);
      gap = cycle - c0;
      check("t4_check_cycles", gap - 2, 1);
      wait_for("t4_end_to", 1, 2000);
      check("t4_exh", exh_b, 1);
      check("t4_tried", tried_b, exp_n);

      // Invalid last byte runs the full scan.
      mode = M_BAD_LAST;
      start_b = 1'b1; tick(); start_b = 1'b0;
      wait_for("t5_done_to", 2, 50);
      c0 = cycle;
      tick();
      wait_for("t5_next_to", 3, 100);
      gap = cycle - c0;
      check("t5_check_cycles", gap - 2, MSG_DEP);
      wait_for("t5_end_to", 1, 2000);
      check("t5_exh", exh_b, 1);

      // Asynchronous reset while scanning the third key.
      base = pulses_a;
      start_a = 1'b1; tick(); start_a = 1'b0;
      want = base + 3;
      wait_for("t6_pulse3_to", 4, 500);
      tick();
      wait_for("t6_done_to", 2, 50);
      repeat (5) tick();
      check("t6_key_before", key_a, FIRST + 2 * STEP);
      #3 reset = 1'b0;
      #1;
      check("t6_rst_key", key_a, 0);
      check("t6_rst_tried", tried_a, 0);
      check("t6_rst_busy", busy_a, 0);
      check("t6_rst_nka", nka_a, 0);
      check("t6_rst_found", found_a, 0);
      check("t6_rst_exh", exh_a, 0);
      tick();
      reset = 1'b1;
      tick();
      base = pulses_a;
      start_a = 1'b1; tick(); start_a = 1'b0;
      check("t6_reissue_nka", nka_a, 1);
      check("t6_reissue_key", key_a, FIRST);

      // Abort while waiting on the core.
      tick();
      check("t7_busy_wait", busy_a, 1);
      abort_a = 1'b1; tick(); abort_a = 1'b0;
      check("t7_abort_busy", busy_a, 0);
      check("t7_abort_nka", nka_a, 0);
      check("t7_abort_found", found_a, 0);
      check("t7_abort_exh", exh_a, 0);
      repeat (10) tick();
      check("t7_no_pulse", pulses_a - base, 1);
      check("t7_idle", busy_a, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
